// File: rtl/mlp_pkg.sv
// rtl/mlp_pkg.sv - shared types, accumulator sizing and saturation helper for the MLP layer
package mlp_pkg;

  typedef enum logic {
    ACT_RELU  = 1'b0,
    ACT_IDENT = 1'b1
  } act_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Wide enough to hold any shifted accumulator the layer can be built with
  localparam int SAT_W = 128;

  // Accumulator holds the shifted bias plus NUM_INPUTS full products without wrapping
  function automatic int acc_width(input int data_width, input int num_inputs);
    return 2 * data_width + $clog2(num_inputs + 1) + 1;
  endfunction

  // Clamp a sign-extended value into the signed range of data_width bits
  function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] v,
                                                      input int data_width);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) << (data_width - 1)) - SAT_W'(1);
    lo = ~hi;
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/mlp_mac_unit.sv
// rtl/mlp_mac_unit.sv - multiply-accumulate, rescale, clamp and activation datapath for one neuron at a time
module mlp_mac_unit
  import mlp_pkg::*;
#(
  parameter int NUM_INPUTS = 2,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  first,
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH-1:0] w,
  input  logic [DATA_WIDTH-1:0] bias,
  input  act_mode_e             act_mode,
  output logic [DATA_WIDTH-1:0] y,
  output logic                  sat
);

  localparam int ACC_W = acc_width(DATA_WIDTH, NUM_INPUTS);

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]        prod_ext;
  logic signed [ACC_W-1:0]        bias_ext;
  logic signed [ACC_W-1:0]        acc;
  logic signed [ACC_W-1:0]        acc_next;
  logic signed [ACC_W-1:0]        r;
  logic signed [SAT_W-1:0]        r_ext;
  logic signed [SAT_W-1:0]        clamped_full;
  logic        [DATA_WIDTH-1:0]   clamped;

  assign prod     = $signed(x) * $signed(w);
  assign prod_ext = {{(ACC_W - 2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
  assign bias_ext = {{(ACC_W - DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias} <<< FRAC_BITS;

  // The first input of a neuron restarts the sum from the rescaled bias
  assign acc_next = first ? (bias_ext + prod_ext) : (acc + prod_ext);

  // Arithmetic shift floors toward minus infinity, matching fixed-point truncation
  assign r            = acc_next >>> FRAC_BITS;
  assign r_ext        = {{(SAT_W - ACC_W){r[ACC_W-1]}}, r};
  assign clamped_full = saturate(r_ext, DATA_WIDTH);
  assign clamped      = clamped_full[DATA_WIDTH-1:0];
  assign sat          = (clamped_full != r_ext);

  // ReLU acts on the clamped value; the clamp flag is reported regardless
  assign y = ((act_mode == ACT_RELU) && (clamped[DATA_WIDTH-1] || (clamped == '0)))
             ? '0 : clamped;

  // Running sum advances only on MAC cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/mlp_layer_seq.sv
// rtl/mlp_layer_seq.sv - sequential fully-connected layer, one multiply per cycle, neuron-major
module mlp_layer_seq
  import mlp_pkg::*;
#(
  parameter int NUM_INPUTS  = 2,
  parameter int NUM_NEURONS = 2,
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = 8
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic                                             in_valid,
  output logic                                             in_ready,
  input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]            in_data,
  input  logic                                             act_mode,
  input  logic [NUM_NEURONS-1:0][NUM_INPUTS-1:0][DATA_WIDTH-1:0] weights,
  input  logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0]           biases,
  output logic                                             out_valid,
  input  logic                                             out_ready,
  output logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0]           out_data,
  output logic [NUM_NEURONS-1:0]                           sat_flag
);

  localparam int IW = (NUM_INPUTS  > 1) ? $clog2(NUM_INPUTS)  : 1;
  localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  localparam logic [1:0] IDLE = 2'(ST_IDLE);
  localparam logic [1:0] MAC  = 2'(ST_MAC);
  localparam logic [1:0] DONE = 2'(ST_DONE);

  logic [1:0]                            state;
  logic [IW-1:0]                         i_cnt;
  logic [NW-1:0]                         n_cnt;
  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] x_reg;
  act_mode_e                             mode_reg;

  logic                  mac_en;
  logic                  first_i;
  logic                  last_i;
  logic                  last_n;
  logic [DATA_WIDTH-1:0] y;
  logic                  sat;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign mac_en    = (state == MAC);
  assign first_i   = (i_cnt == '0);
  assign last_i    = (i_cnt == IW'(NUM_INPUTS - 1));
  assign last_n    = (n_cnt == NW'(NUM_NEURONS - 1));

  // Control: accept a vector, sweep neurons then inputs, hold the result until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      i_cnt    <= '0;
      n_cnt    <= '0;
      x_reg    <= '0;
      mode_reg <= ACT_RELU;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_reg    <= in_data;
            mode_reg <= act_mode_e'(act_mode);
            i_cnt    <= '0;
            n_cnt    <= '0;
            state    <= MAC;
          end
        end
        MAC: begin
          if (last_i) begin
            i_cnt <= '0;
            if (last_n) begin
              n_cnt <= '0;
              state <= DONE;
            end else begin
              n_cnt <= n_cnt + NW'(1);
            end
          end else begin
            i_cnt <= i_cnt + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Each neuron's result lands in its slot on the edge closing its last MAC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      sat_flag <= '0;
    end else if (mac_en && last_i) begin
      out_data[n_cnt] <= y;
      sat_flag[n_cnt] <= sat;
    end
  end

  mlp_mac_unit #(
    .NUM_INPUTS (NUM_INPUTS),
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS)
  ) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (mac_en),
    .first    (first_i),
    .x        (x_reg[i_cnt]),
    .w        (weights[n_cnt][i_cnt]),
    .bias     (biases[n_cnt]),
    .act_mode (mode_reg),
    .y        (y),
    .sat      (sat)
  );

endmodule

// File: tb/tb_mlp_layer_seq.sv
// tb/tb_mlp_layer_seq.sv - randomized self-checking bench for mlp_layer_seq against an arithmetic model
module tb_mlp_layer_seq;

  localparam int NI = 2;
  localparam int NN = 2;
  localparam int DW = 16;
  localparam int FB = 8;

  logic                          clk;
  logic                          rst_n;
  logic                          in_valid;
  logic                          in_ready;
  logic [NI-1:0][DW-1:0]         in_data;
  logic                          act_mode;
  logic [NN-1:0][NI-1:0][DW-1:0] weights;
  logic [NN-1:0][DW-1:0]         biases;
  logic                          out_valid;
  logic                          out_ready;
  logic [NN-1:0][DW-1:0]         out_data;
  logic [NN-1:0]                 sat_flag;

  int n_cmp = 0;
  int n_bad = 0;

  longint exp_y [NN];
  bit     exp_s [NN];

  mlp_layer_seq #(
    .NUM_INPUTS  (NI),
    .NUM_NEURONS (NN),
    .DATA_WIDTH  (DW),
    .FRAC_BITS   (FB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .act_mode  (act_mode),
    .weights   (weights),
    .biases    (biases),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sat_flag  (sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: real-valued fixed-point layer with floor rescale, clamp, then activation
  task automatic compute_expected(input logic [NI-1:0][DW-1:0] x, input logic m);
    longint acc;
    longint r;
    longint lim;
    lim = longint'(1) << (DW - 1);
    for (int n = 0; n < NN; n++) begin
      acc = longint'($signed(biases[n])) * (longint'(1) << FB);
      for (int i = 0; i < NI; i++) begin
        acc += longint'($signed(x[i])) * longint'($signed(weights[n][i]));
      end
      r = acc >>> FB;
      exp_s[n] = 1'b0;
      if (r > lim - 1) begin
        r = lim - 1;
        exp_s[n] = 1'b1;
      end else if (r < -lim) begin
        r = -lim;
        exp_s[n] = 1'b1;
      end
      if (!m && r <= 0) r = 0;
      exp_y[n] = r;
    end
  endtask

  task automatic check_results(input string tag);
    for (int n = 0; n < NN; n++) begin
      chk($sformatf("%s_data%0d", tag, n), $signed(out_data[n]), exp_y[n]);
      chk($sformatf("%s_sat%0d", tag, n), sat_flag[n], exp_s[n]);
    end
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < NI; i++) in_data[i] = DW'($urandom);
    act_mode = 1'($urandom);
  endtask

  task automatic run_vector(input logic [NI-1:0][DW-1:0] x, input logic m, input int hold);
    int cyc;
    compute_expected(x, m);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_data   = x;
    act_mode  = m;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    randomize_inputs();
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    chk("latency", cyc, NN * NI);
    check_results("result");
    repeat (hold) begin
      in_valid = 1'($urandom);
      randomize_inputs();
      @(posedge clk);
      @(negedge clk);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      check_results("hold");
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_out_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
  endtask

  function automatic logic [DW-1:0] rnd_val();
    if ($urandom_range(0, 2) == 0) return DW'($urandom);
    return DW'(int'($urandom_range(0, 1023)) - 512);
  endfunction

  initial begin
    logic [NI-1:0][DW-1:0] xa;
    logic [NI-1:0][DW-1:0] xb;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    act_mode  = 1'b0;
    weights   = '0;
    biases    = '0;

    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_sat_flag", sat_flag, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);

    weights[0] = '{16'sd256, 16'sd256};
    biases[0]  = -16'sd256;
    weights[1] = '{16'sd100, -16'sd50};
    biases[1]  = 16'sd3;
    xa = '{16'sd256, 16'sd256};
    run_vector(xa, 1'b0, 0);

    xa = '{16'sd0, 16'sd0};
    run_vector(xa, 1'b0, 0);
    run_vector(xa, 1'b1, 0);

    weights[1] = '{16'sd32767, 16'sd32767};
    biases[1]  = 16'sd32767;
    xa = '{16'sd32767, 16'sd32767};
    run_vector(xa, 1'b0, 5);

    weights = {NN * NI{16'h8000}};
    biases  = {NN{16'h8000}};
    run_vector(xa, 1'b1, 2);

    weights[0] = '{16'sd512, -16'sd300};
    weights[1] = '{-16'sd77, 16'sd1000};
    biases     = '{16'sd40, -16'sd900};
    xa = '{16'sd700, 16'sd123};
    @(negedge clk);
    in_data  = xa;
    act_mode = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_rel_in_ready", in_ready, 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("midrst_no_result", out_valid, 0);
    end
    run_vector(xa, 1'b1, 1);

    xa = '{-16'sd1000, 16'sd250};
    xb = '{16'sd333, -16'sd4000};
    compute_expected(xa, 1'b1);
    @(negedge clk);
    in_data   = xa;
    act_mode  = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) begin
        in_data  = xb;
        act_mode = 1'b0;
      end
      if (k == 6) in_valid = 1'b0;
      chk($sformatf("b2b_out_valid_k%0d", k), out_valid, (k == 4 || k == 10) ? 1 : 0);
      chk($sformatf("b2b_in_ready_k%0d", k), in_ready, (k == 5 || k == 11) ? 1 : 0);
      if (k == 4) begin
        check_results("b2b_a");
        compute_expected(xb, 1'b0);
      end
      if (k == 10) check_results("b2b_b");
      @(posedge clk);
    end
    @(negedge clk);
    out_ready = 1'b0;

    for (int t = 0; t < 25; t++) begin
      for (int n = 0; n < NN; n++) begin
        for (int i = 0; i < NI; i++) weights[n][i] = rnd_val();
        biases[n] = rnd_val();
      end
      for (int i = 0; i < NI; i++) xa[i] = rnd_val();
      run_vector(xa, 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
